// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared definitions for the seg7_scan_mux display driver.
//                Holds the segment bit positions, the hex-to-seven-segment
//                decoder and a parameter range-check macro.
//                Exports: SEG_W, SEG_A..SEG_G, hex7(), `SEG7_PARAM_CHECK.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef SEG7_PKG_SV
`define SEG7_PKG_SV

// Elaboration-time range check. It is placed inside a module body. LABEL names
// the generate block, so each use needs a unique label.
`define SEG7_PARAM_CHECK(LABEL, COND, MSG) \
  if (!(COND)) begin : LABEL \
    $error(MSG); \
  end

package seg7_pkg;

  // Segment bit positions inside the 7-bit segment bus (abcdefg, a is the MSB).
  localparam int unsigned SEG_W = 7;
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  // One 16-bit lit-mask per segment: bit n is set when hex digit n lights
  // that segment. Decoding becomes one table lookup per segment.
  localparam logic [15:0] C_MASK_A = 16'hD7ED;
  localparam logic [15:0] C_MASK_B = 16'h279F;
  localparam logic [15:0] C_MASK_C = 16'h2FFB;
  localparam logic [15:0] C_MASK_D = 16'h7B6D;
  localparam logic [15:0] C_MASK_E = 16'hFD45;
  localparam logic [15:0] C_MASK_F = 16'hDF71;
  localparam logic [15:0] C_MASK_G = 16'hEF7C;

  // Hex nibble to active-high abcdefg pattern (b and d in lower case).
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    seg        = '0;
    seg[SEG_A] = C_MASK_A[nib];
    seg[SEG_B] = C_MASK_B[nib];
    seg[SEG_C] = C_MASK_C[nib];
    seg[SEG_D] = C_MASK_D[nib];
    seg[SEG_E] = C_MASK_E[nib];
    seg[SEG_F] = C_MASK_F[nib];
    seg[SEG_G] = C_MASK_G[nib];
    return seg;
  endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/seg7_scan_mux_lzb.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux_lzb
//  Description : Combinational leading-zero blank mask. Bit k is set when
//                blanking is enabled and every nibble at index >= k is zero.
//                Bit 0 is never set, so an all-zero value still shows "0".
//  Ports       : shadow_num_i  [4*DIGITS] snapshot of the displayed value
//                shadow_zb_i   [1]        leading-zero blanking enable
//                blank_mask_o  [DIGITS]   per-digit blank request
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_mux_lzb
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] shadow_num_i,
  input  logic                shadow_zb_i,
  output logic [DIGITS-1:0]   blank_mask_o
);

  logic w_upper_nz;

  // Walk from the most significant digit down, remembering whether any
  // nonzero nibble has been seen at or above the current index.
  always_comb begin
    w_upper_nz   = 1'b0;
    blank_mask_o = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_upper_nz      = w_upper_nz | (|shadow_num_i[4*k +: 4]);
      blank_mask_o[k] = shadow_zb_i & ~w_upper_nz;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux
//  Description : Time-multiplexed seven-segment driver for DIGITS hex digits
//                with per-digit DP, leading-zero blanking, anti-ghost blank
//                interval, frame-synchronous snapshot and frame-done strobe.
//  Ports       : I_clk, I_rst_n (async, active-low)
//                I_show_num [4*DIGITS] value, nibble k on digit k
//                I_dp [DIGITS] decimal points, I_en enable,
//                I_zero_blank leading-zero suppression
//                O_led [7] abcdefg, O_dp, O_px [DIGITS] one-hot digit select,
//                O_frame_done one-cycle end-of-frame pulse
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DIV_CNT        = 100000,
  parameter int BLANK_CNT      = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic [4*DIGITS-1:0] I_show_num,
  input  logic [DIGITS-1:0]   I_dp,
  input  logic                I_en,
  input  logic                I_zero_blank,
  output logic [SEG_W-1:0]    O_led,
  output logic                O_dp,
  output logic [DIGITS-1:0]   O_px,
  output logic                O_frame_done
);

  `SEG7_PARAM_CHECK(g_chk_digits, (DIGITS >= 1) && (DIGITS <= 16), "seg7_scan_mux: DIGITS must be 1..16")
  `SEG7_PARAM_CHECK(g_chk_div,    DIV_CNT >= 2,                    "seg7_scan_mux: DIV_CNT must be >= 2")
  `SEG7_PARAM_CHECK(g_chk_blank,  (BLANK_CNT >= 0) && (BLANK_CNT < DIV_CNT), "seg7_scan_mux: BLANK_CNT must be 0..DIV_CNT-1")

  localparam int CW = $clog2(DIV_CNT);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] C_LAST_CNT = CW'(DIV_CNT - 1);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DIGITS - 1);

  // State
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_num_q;
  logic [DIGITS-1:0]     shadow_dp_q;
  logic                  shadow_zb_q;
  logic                  init_q;
  logic                  done_q;
  logic [DIGITS-1:0]     px_q, px_d;
  logic [SEG_W-1:0]      led_q, led_d;
  logic                  dp_q, dp_d;

  // Combinational helpers
  logic                  w_cnt_wrap;
  logic                  w_idx_wrap;
  logic                  w_frame_end;
  logic                  w_load;
  logic                  w_in_blank;
  logic [DIGITS-1:0]     w_blank_mask;
  logic [DIGITS-1:0]     w_onehot;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_blank_sel;

  seg7_scan_mux_lzb #(
    .DIGITS (DIGITS)
  ) u_lzb (
    .shadow_num_i (shadow_num_q),
    .shadow_zb_i  (shadow_zb_q),
    .blank_mask_o (w_blank_mask)
  );

  // The guard comparison only exists when a guard interval is configured;
  // with BLANK_CNT = 0 an unsigned "< 0" test would be a constant.
  if (BLANK_CNT > 0) begin : g_blank_guard
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CNT);
    assign w_in_blank = (cnt_q < C_BLANK);
  end else begin : g_no_blank_guard
    assign w_in_blank = 1'b0;
  end

  always_comb begin
    w_cnt_wrap  = (cnt_q == C_LAST_CNT);
    w_idx_wrap  = (idx_q == C_LAST_IDX);
    w_frame_end = I_en & w_cnt_wrap & w_idx_wrap;
    // Snapshot is transparent while disabled, right after reset, and at the
    // frame boundary; otherwise the whole frame uses one consistent value.
    w_load      = ~I_en | init_q | w_frame_end;

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!I_en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (w_cnt_wrap) begin
      cnt_d = '0;
      idx_d = w_idx_wrap ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Select the current digit with compares rather than a variable
    // part-select, so a non-power-of-two DIGITS never indexes past the end.
    w_onehot    = '0;
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        w_onehot[k] = 1'b1;
        w_nib       = shadow_num_q[4*k +: 4];
        w_dp_sel    = shadow_dp_q[k];
        w_blank_sel = w_blank_mask[k];
      end
    end

    px_d  = '0;
    led_d = '0;
    dp_d  = 1'b0;
    if (I_en && !w_in_blank) begin
      px_d  = w_onehot;
      led_d = w_blank_sel ? '0 : hex7(w_nib);
      dp_d  = w_dp_sel;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_num_q <= '0;
      shadow_dp_q  <= '0;
      shadow_zb_q  <= 1'b0;
      init_q       <= 1'b1;
      done_q       <= 1'b0;
      px_q         <= '0;
      led_q        <= '0;
      dp_q         <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      init_q <= 1'b0;
      done_q <= w_frame_end;
      px_q   <= px_d;
      led_q  <= led_d;
      dp_q   <= dp_d;
      if (w_load) begin
        shadow_num_q <= I_show_num;
        shadow_dp_q  <= I_dp;
        shadow_zb_q  <= I_zero_blank;
      end
    end
  end

  // Polarity is applied only here, so reset also lands on the inactive level.
  assign O_led        = led_q ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign O_dp         = dp_q ^ SEG_ACTIVE_LOW;
  assign O_px         = px_q ^ {DIGITS{DIG_ACTIVE_LOW}};
  // Masked by I_en so a pulse can never appear while the display is off.
  assign O_frame_done = done_q & I_en;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_mux
//  Description : Directed self-checking bench for seg7_scan_mux with
//                DIGITS=4, DIV_CNT=4, BLANK_CNT=1. A second instance with
//                both polarities inverted shares the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] show;
  logic [3:0]  dp;
  logic        en;
  logic        zb;

  logic [6:0]  led,    led_al;
  logic        dpo,    dpo_al;
  logic [3:0]  px,     px_al;
  logic        fd,     fd_al;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .DIGITS(4), .DIV_CNT(4), .BLANK_CNT(1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_show_num(show), .I_dp(dp), .I_en(en),
    .I_zero_blank(zb), .O_led(led), .O_dp(dpo), .O_px(px), .O_frame_done(fd)
  );

  seg7_scan_mux #(
    .DIGITS(4), .DIV_CNT(4), .BLANK_CNT(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_al (
    .I_clk(clk), .I_rst_n(rst_n), .I_show_num(show), .I_dp(dp), .I_en(en),
    .I_zero_blank(zb), .O_led(led_al), .O_dp(dpo_al), .O_px(px_al), .O_frame_done(fd_al)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp_v, k);
    end
  endtask

  // Checks all outputs of both instances against the given logical values.
  task automatic chk_all(input logic [3:0] e_px, input logic [6:0] e_led,
                         input logic e_dp, input logic e_fd);
    chk("px",    {28'b0, px},     {28'b0, e_px});
    chk("led",   {25'b0, led},    {25'b0, e_led});
    chk("dp",    {31'b0, dpo},    {31'b0, e_dp});
    chk("fdone", {31'b0, fd},     {31'b0, e_fd});
    chk("al_px", {28'b0, px_al},  {28'b0, ~e_px});
    chk("al_led",{25'b0, led_al}, {25'b0, ~e_led});
    chk("al_dp", {31'b0, dpo_al}, {31'b0, ~e_dp});
    chk("al_fd", {31'b0, fd_al},  {31'b0, e_fd});
  endtask

  // Step n enabled cycles. After edge k the outputs reflect slot
  // cnt=(k-1)%4 of digit ((k-1)/4)%4; a frame is 16 edges long.
  task automatic scan(input int n, input logic [15:0] val, input logic [3:0] dpv, input logic zbv);
    int         c;
    int         d;
    logic [3:0] nib;
    logic       blk;
    logic [3:0] e_px;
    logic [6:0] e_led;
    logic       e_dp;
    logic       e_fd;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      k++;
      c     = (k - 1) % 4;
      d     = ((k - 1) / 4) % 4;
      nib   = val[4*d +: 4];
      blk   = zbv && (d != 0) && ((val >> (4*d)) == 16'h0);
      e_px  = (c == 0) ? 4'h0 : 4'(1 << d);
      e_led = (c == 0 || blk) ? 7'h00 : HEX[nib];
      e_dp  = (c != 0) && dpv[d];
      e_fd  = (k % 16 == 0);
      chk_all(e_px, e_led, e_dp, e_fd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk_all(4'h0, 7'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    show  = 16'h1234;
    dp    = 4'h0;
    zb    = 1'b0;

    // Reset state, including inverted pin levels on the active-low instance
    repeat (3) @(posedge clk);
    #1;
    chk_all(4'h0, 7'h00, 1'b0, 1'b0);

    // Basic scan of 1234: digits show 4,3,2,1; frame pulse every 16 cycles
    rst_n = 1'b1;
    k     = 0;
    scan(32, 16'h1234, 4'h0, 1'b0);

    // Input change mid-frame while idx=1 is held off until the frame ends
    scan(5, 16'h1234, 4'h0, 1'b0);
    show = 16'hABCD;
    scan(11, 16'h1234, 4'h0, 1'b0);
    scan(16, 16'hABCD, 4'h0, 1'b0);

    // Leading-zero blanking of 0050
    zb   = 1'b1;
    show = 16'h0050;
    scan(16, 16'hABCD, 4'h0, 1'b0);
    scan(16, 16'h0050, 4'h0, 1'b1);

    // All-zero value keeps a single 0 on digit 0
    show = 16'h0000;
    scan(16, 16'h0050, 4'h0, 1'b1);
    scan(16, 16'h0000, 4'h0, 1'b1);

    // DP on a blanked digit
    show = 16'h0007;
    dp   = 4'b0100;
    scan(16, 16'h0000, 4'h0, 1'b1);
    scan(16, 16'h0007, 4'b0100, 1'b1);

    // Digit 0 showing 8 (active-low instance: led 0000000, px 1110)
    show = 16'h0008;
    dp   = 4'h0;
    zb   = 1'b0;
    scan(16, 16'h0007, 4'b0100, 1'b1);
    scan(16, 16'h0008, 4'h0, 1'b0);

    // Disable while idx=2: outputs off next cycle, no frame pulse
    scan(9, 16'h0008, 4'h0, 1'b0);
    en   = 1'b0;
    show = 16'h4321;
    idle(20);

    // Re-enable: fresh snapshot, restart at digit 0 after one blank cycle
    en = 1'b1;
    k  = 0;
    scan(16, 16'h4321, 4'h0, 1'b0);
    scan(2, 16'h4321, 4'h0, 1'b0);

    // Asynchronous reset mid-slot clears outputs before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(4'h0, 7'h00, 1'b0, 1'b0);
    show = 16'h8765;
    repeat (2) @(posedge clk);
    #1;
    chk_all(4'h0, 7'h00, 1'b0, 1'b0);

    // First cycle after release takes a snapshot
    rst_n = 1'b1;
    k     = 0;
    scan(16, 16'h8765, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
